// File: rtl/mcast_copy_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// mcast_copy_sequencer_pkg
// Shared packet-type codes, coordinate widths and FSM state encoding.
// Revision: 1.0
// ============================================================================
package mcast_copy_sequencer_pkg;

    localparam int COORD_W = 3;
    localparam int TGT_W   = 6;

    localparam logic [1:0] PKT_UNI   = 2'b00;
    localparam logic [1:0] PKT_COL   = 2'b01;
    localparam logic [1:0] PKT_ROW   = 2'b10;
    localparam logic [1:0] PKT_BCAST = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

endpackage : mcast_copy_sequencer_pkg
`default_nettype wire

// File: rtl/mcast_copy_sequencer_tgt_step.sv
`default_nettype none
// ============================================================================
// mcast_copy_sequencer_tgt_step
// Combinational row-major walker: first target of a sweep, or its successor.
// Revision: 1.0
// ============================================================================
module mcast_copy_sequencer_tgt_step
    import mcast_copy_sequencer_pkg::*;
(
    input  logic [1:0]       pkt_type_i,
    input  logic [TGT_W-1:0] cur_i,
    input  logic             load_i,
    output logic [TGT_W-1:0] nxt_o,
    output logic             raw_last_o
);

    logic [COORD_W-1:0] w_x;
    logic [COORD_W-1:0] w_y;
    logic [TGT_W-1:0]   w_first;
    logic [TGT_W-1:0]   w_step;

    assign w_x = cur_i[COORD_W-1:0];
    assign w_y = cur_i[TGT_W-1:COORD_W];

    always_comb begin
        w_first    = cur_i;
        w_step     = cur_i;
        raw_last_o = 1'b1;
        case (pkt_type_i)
            PKT_COL: begin
                w_first    = {{COORD_W{1'b0}}, w_x};
                w_step     = {w_y + 3'd1, w_x};
                raw_last_o = (w_y == 3'd7);
            end
            PKT_ROW: begin
                w_first    = {w_y, {COORD_W{1'b0}}};
                w_step     = {w_y, w_x + 3'd1};
                raw_last_o = (w_x == 3'd7);
            end
            PKT_BCAST: begin
                // x+1 with carry into y is a plain 6-bit increment
                w_first    = {TGT_W{1'b0}};
                w_step     = cur_i + 6'd1;
                raw_last_o = (cur_i == 6'h3F);
            end
            default: begin
                w_first    = cur_i;
                w_step     = cur_i;
                raw_last_o = 1'b1;
            end
        endcase
    end

    assign nxt_o = load_i ? w_first : w_step;

endmodule : mcast_copy_sequencer_tgt_step
`default_nettype wire

// File: rtl/mcast_copy_sequencer.sv
`default_nettype none
// ============================================================================
// mcast_copy_sequencer
// Accepts one packet and emits one unicast copy per mesh destination.
// Revision: 1.0
// ============================================================================
module mcast_copy_sequencer
    import mcast_copy_sequencer_pkg::*;
#(
    parameter logic [2:0] LOCAL_X    = 3'd0,
    parameter logic [2:0] LOCAL_Y    = 3'd0,
    parameter int         DATA_W     = 32,
    parameter bit         SKIP_LOCAL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld_i,
    output logic              in_rdy_o,
    input  logic [1:0]        in_pkt_type_i,
    input  logic [TGT_W-1:0]  in_tgt_i,
    input  logic [DATA_W-1:0] in_payload_i,
    output logic              out_vld_o,
    input  logic              out_rdy_i,
    output logic [TGT_W-1:0]  out_tgt_o,
    output logic [DATA_W-1:0] out_payload_o,
    output logic              out_last_o,
    output logic [TGT_W-1:0]  out_seq_o,
    output logic              busy_o
);

    localparam logic [TGT_W-1:0] LOCAL_TGT = {LOCAL_Y, LOCAL_X};

    state_e              state_q, state_d;
    logic [1:0]          type_q, type_d;
    logic [TGT_W-1:0]    cur_q, cur_d;
    logic [DATA_W-1:0]   payload_q, payload_d;
    logic [TGT_W-1:0]    seq_q, seq_d;

    logic                w_idle;
    logic [1:0]          w_type;
    logic [TGT_W-1:0]    w_cur;
    logic [TGT_W-1:0]    w_nxt_a;
    logic [TGT_W-1:0]    w_nxt_b;
    logic                w_raw_last_a;
    logic                w_raw_last_b;
    logic                w_skip_en;
    logic                w_hop_local;
    logic [TGT_W-1:0]    w_nxt;
    logic                w_last;
    logic                w_fire;

    // In IDLE the walkers see the incoming packet; in SEND they see the held copy.
    assign w_idle = (state_q == ST_IDLE);
    assign w_type = w_idle ? in_pkt_type_i : type_q;
    assign w_cur  = w_idle ? in_tgt_i      : cur_q;

    mcast_copy_sequencer_tgt_step u_step_cur (
        .pkt_type_i (w_type),
        .cur_i      (w_cur),
        .load_i     (w_idle),
        .nxt_o      (w_nxt_a),
        .raw_last_o (w_raw_last_a)
    );

    mcast_copy_sequencer_tgt_step u_step_nxt (
        .pkt_type_i (w_type),
        .cur_i      (w_nxt_a),
        .load_i     (1'b0),
        .nxt_o      (w_nxt_b),
        .raw_last_o (w_raw_last_b)
    );

    // Landing on the local node hops one position further, so no bubble is needed.
    assign w_skip_en   = SKIP_LOCAL && (w_type != PKT_UNI);
    assign w_hop_local = w_skip_en && (w_nxt_a == LOCAL_TGT);
    assign w_nxt       = w_hop_local ? w_nxt_b : w_nxt_a;
    assign w_last      = w_raw_last_a | (w_hop_local & w_raw_last_b);
    assign w_fire      = (state_q == ST_SEND) && out_rdy_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_vld_i)         state_d = ST_SEND;
            ST_SEND: if (w_fire && w_last) state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_rdy_o   = 1'b0;
        out_vld_o  = 1'b0;
        busy_o     = 1'b0;
        out_last_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_rdy_o = 1'b1;
            end
            ST_SEND: begin
                out_vld_o  = 1'b1;
                busy_o     = 1'b1;
                out_last_o = w_last;
            end
            default: begin
                in_rdy_o = 1'b0;
            end
        endcase
    end

    always_comb begin
        type_d    = type_q;
        cur_d     = cur_q;
        payload_d = payload_q;
        seq_d     = seq_q;
        if (w_idle && in_vld_i) begin
            type_d    = in_pkt_type_i;
            cur_d     = w_nxt;
            payload_d = in_payload_i;
            seq_d     = {TGT_W{1'b0}};
        end else if (w_fire && !w_last) begin
            cur_d = w_nxt;
            seq_d = seq_q + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            type_q    <= PKT_UNI;
            cur_q     <= {TGT_W{1'b0}};
            payload_q <= {DATA_W{1'b0}};
            seq_q     <= {TGT_W{1'b0}};
        end else begin
            type_q    <= type_d;
            cur_q     <= cur_d;
            payload_q <= payload_d;
            seq_q     <= seq_d;
        end
    end

    assign out_tgt_o     = cur_q;
    assign out_payload_o = payload_q;
    assign out_seq_o     = seq_q;

endmodule : mcast_copy_sequencer
`default_nettype wire

// File: tb/tb_mcast_copy_sequencer.sv
`default_nettype none
// ============================================================================
// tb_mcast_copy_sequencer
// Four differently configured sequencers checked against a row-major destination model.
// Revision: 1.0
// ============================================================================
module tb_mcast_copy_sequencer;

    localparam int NDUT = 4;
    localparam int LX [NDUT] = '{2, 0, 0, 5};
    localparam int LY [NDUT] = '{3, 7, 0, 5};
    localparam int SK [NDUT] = '{1, 1, 1, 0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  in_type = 2'b00;
    logic [5:0]  in_tgt = 6'd0;
    logic [31:0] in_payload = 32'd0;
    logic        out_rdy = 1'b0;

    logic        in_vld      [NDUT];
    logic        in_rdy      [NDUT];
    logic        out_vld     [NDUT];
    logic [5:0]  out_tgt     [NDUT];
    logic [31:0] out_payload [NDUT];
    logic        out_last    [NDUT];
    logic [5:0]  out_seq     [NDUT];
    logic        busy        [NDUT];

    int n_chk = 0;
    int n_err = 0;
    logic [5:0] exp_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mcast_copy_sequencer #(
            .LOCAL_X    (3'(LX[g])),
            .LOCAL_Y    (3'(LY[g])),
            .DATA_W     (32),
            .SKIP_LOCAL (SK[g] != 0)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .in_vld_i      (in_vld[g]),
            .in_rdy_o      (in_rdy[g]),
            .in_pkt_type_i (in_type),
            .in_tgt_i      (in_tgt),
            .in_payload_i  (in_payload),
            .out_vld_o     (out_vld[g]),
            .out_rdy_i     (out_rdy),
            .out_tgt_o     (out_tgt[g]),
            .out_payload_o (out_payload[g]),
            .out_last_o    (out_last[g]),
            .out_seq_o     (out_seq[g]),
            .busy_o        (busy[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic r, input logic b, input logic v,
                                       input logic l, input logic [5:0] s,
                                       input logic [5:0] t, input logic [31:0] p);
        return {16'b0, r, b, v, l, s, t, p};
    endfunction

    function automatic logic [63:0] obs(input int d);
        return mk(in_rdy[d], busy[d], out_vld[d], out_last[d], out_seq[d], out_tgt[d], out_payload[d]);
    endfunction

    // Destination set walked in row-major order; local node dropped when skipping.
    task automatic build(input int d, input logic [1:0] t, input logic [5:0] tg);
        exp_q.delete();
        if (t == 2'b00) begin
            exp_q.push_back(tg);
        end else begin
            for (int y = 0; y < 8; y++) begin
                for (int x = 0; x < 8; x++) begin
                    bit in_set;
                    bit is_loc;
                    in_set = (t == 2'b11) || (t == 2'b01 && x == int'(tg[2:0]))
                             || (t == 2'b10 && y == int'(tg[5:3]));
                    is_loc = (x == LX[d]) && (y == LY[d]);
                    if (in_set && !(SK[d] != 0 && is_loc))
                        exp_q.push_back({3'(y), 3'(x)});
                end
            end
        end
    endtask

    // mode 0: always ready, 1: toggle 1/0, 2: random. rst_at >= 0 resets while that copy shows.
    task automatic send_pkt(input int d, input logic [1:0] t, input logic [5:0] tg,
                            input logic [31:0] pl, input int mode, input bit hold,
                            input int rst_at);
        int k;
        int cyc;
        int sz;
        bit phase;
        bit rdy;
        logic [63:0] o;
        build(d, t, tg);
        sz = exp_q.size();
        check("in_rdy_idle", 64'(in_rdy[d]), 64'd1);
        in_vld[d]  = 1'b1;
        in_type    = t;
        in_tgt     = tg;
        in_payload = pl;
        out_rdy    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (!hold) in_vld[d] = 1'b0;
        k = 0;
        cyc = 0;
        phase = 1'b1;
        while (k < sz && cyc < 1000) begin
            if (hold) begin
                in_type    = 2'($urandom_range(0, 3));
                in_tgt     = 6'($urandom);
                in_payload = $urandom;
            end
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? phase : 1'($urandom_range(0, 1));
            phase = ~phase;
            out_rdy = rdy;
            check("copy", obs(d), mk(1'b0, 1'b1, 1'b1, (k == sz - 1), 6'(k), exp_q[k], pl));
            if (k == rst_at) begin
                in_vld[d] = 1'b0;
                rst = 1'b1;
                out_rdy = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check("mid_reset", obs(d), mk(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 32'd0));
                rst = 1'b0;
                return;
            end
            @(posedge clk);
            @(negedge clk);
            if (rdy) k++;
            cyc++;
        end
        check("copies_done", 64'(k), 64'(sz));
        in_vld[d] = 1'b0;
        out_rdy   = 1'b0;
        o = obs(d);
        check("idle_after", 64'(o[47:44]), 64'(4'b1000));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] o;
        for (int i = 0; i < NDUT; i++) in_vld[i] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NDUT; i++)
            check("reset", obs(i), mk(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 32'd0));
        rst = 1'b0;
        @(negedge clk);

        send_pkt(0, 2'b00, 6'h15, 32'hA5A5A5A5, 0, 1'b0, -1);
        send_pkt(0, 2'b00, 6'h1A, 32'h0000BEEF, 0, 1'b0, -1);
        send_pkt(0, 2'b10, 6'h18, 32'h12345678, 0, 1'b0, -1);
        send_pkt(1, 2'b01, 6'h00, 32'hCAFEF00D, 0, 1'b0, -1);
        send_pkt(2, 2'b11, 6'h2A, 32'hDEADBEEF, 1, 1'b0, -1);
        send_pkt(2, 2'b11, 6'h00, 32'h55AA55AA, 0, 1'b0, 4);
        send_pkt(2, 2'b11, 6'h00, 32'h0BADC0DE, 2, 1'b0, -1);
        send_pkt(3, 2'b01, 6'h05, 32'h87654321, 0, 1'b1, -1);
        send_pkt(3, 2'b10, 6'h2B, 32'h13579BDF, 2, 1'b1, -1);

        for (int n = 0; n < 40; n++) begin
            send_pkt($urandom_range(0, NDUT - 1), 2'($urandom_range(0, 3)), 6'($urandom),
                     $urandom, $urandom_range(0, 2), 1'($urandom_range(0, 1)), -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        o = obs(1);
        check("final_idle", 64'(o[47:45]), 64'(3'b100));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_mcast_copy_sequencer
`default_nettype wire
